alu_nibble_sequencer: RTL
=========================

// Module: alu_nibble_sequencer
// PURPOSE
//  Runs WIDTH-bit ALU operations through one 4-bit ta181_bar slice, one nibble per cycle, LSB first.
//  Carry is chained between nibbles in a register, and the result is assembled with flags.
//  Sits between the microprocessor control unit (request/response handshake) and the shared ALU slice.
//  Lets the 8-bit datapath use a single 74x181-style slice instead of a cascaded pair.
// PARAMETERS
//  NIBBLES  2  number of 4-bit passes; operand width WIDTH = 4*NIBBLES
// PORTS
//  CLK        in   1      rising-edge clock
//  RESET      in   1      synchronous, active-high reset
//  START      in   1      request valid; accepted only when READY=1
//  READY      out  1      1 in IDLE only
//  A          in   WIDTH  operand A, active-high, sampled on accept
//  B          in   WIDTH  operand B, active-high, sampled on accept
//  S          in   4      function select, sampled on accept
//  M          in   1      0 = arithmetic, 1 = logic; sampled on accept
//  CIN        in   1      carry in, slice polarity (1 = no carry for add); sampled on accept
//  RES_VALID  out  1      result valid; held until RES_READY
//  RES_READY  in   1      consumer takes the result
//  RESULT     out  WIDTH  assembled F, active-high
//  COUT       out  1      CO of the final nibble, slice polarity
//  AEQB       out  1      AND of the per-nibble AEQB outputs
//  ZERO       out  1      RESULT == 0
// BEHAVIOUR
//  - Reset values: READY=1 (IDLE), RES_VALID=0, RESULT=0, COUT=1, AEQB=0, ZERO=0.
//  - All internal registers are cleared on reset.
//  - State IDLE, START=1: capture A, B, S, M and CIN; nibble count <= 0; carry register <= CIN; go to RUN.
//  - State RUN: the slice is driven from registered data only.
//    - Slice A_BAR/B_BAR inputs = ~nibble[cnt] of the captured operands.
//    - Slice S/M inputs = the captured S and M; slice CI = the carry register.
//    - F is taken as ~F_BAR.
//  - Each RUN clock edge:
//    - RESULT nibble[cnt] <= F.
//    - Carry register <= CO.
//    - AEQB accumulator &= slice AEQB.
//    - cnt++.
//  - On the edge where cnt == NIBBLES-1:
//    - COUT <= CO.
//    - ZERO is computed from the complete result.
//    - Go to DONE.
//  - State DONE: RES_VALID=1.
//    - RESULT, COUT, AEQB and ZERO are stable and held until RES_READY=1.
//    - On that edge go to IDLE.
//  - Latency: accept at edge N -> RES_VALID=1 from cycle N+NIBBLES+1. For NIBBLES=2, accept at edge 0 -> RES_VALID in cycle 3.
//  - Throughput: one operation per NIBBLES+2 cycles at best, because READY returns the cycle after RES_READY.
//  - M=1: carry is still chained. The slice ignores CI in logic mode, and COUT is reported unmodified.
//  - START while READY=0 is ignored: no queuing, no error.
//  - A, B, S, M and CIN may change after accept without effect.
//  - RESET asserted in RUN or DONE aborts the operation: IDLE and reset values on the next edge; the partial result is discarded.
//  - RES_READY outside DONE is ignored.
//  - In DONE, RES_READY and a new START in the same cycle: START is not accepted (READY=0); it is accepted one cycle later in IDLE.
//  - The nibble counter is $clog2(NIBBLES)+1 bits wide and never wraps past NIBBLES-1.
// STRUCTURE
//  - Shared package: state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
//  - Shared package: the ALU function-select constants used by the control unit:
//    - FN_ADD=4'b1001, FN_SUB=4'b0110
//    - FN_XOR=4'b0110, FN_AND=4'b1011, FN_OR=4'b1110
//  - One sub-module: ta181_bar, instantiated once. Its P_BAR/G_BAR outputs are left unused.
//  - The FSM, nibble mux and result register are in this module.
// TESTING
//  1. Reset mid-RUN: outputs hold reset values the next cycle, READY=1, RES_VALID=0.
//  2. ADD: A=8'h3C, B=8'h45, S=1001, M=0, CIN=1 -> RESULT=8'h81, COUT=1, ZERO=0; RES_VALID in cycle 3 after accept.
//  3. ADD with overflow: A=8'hF0, B=8'h20, S=1001, M=0, CIN=1 -> RESULT=8'h10, COUT=0 (carry out, active-low).
//  4. SUB: A=8'h50, B=8'h50, S=0110, M=0, CIN=0 -> RESULT=8'h00, ZERO=1, AEQB=1.
//  5. XOR: A=8'hCA, B=8'h0F, S=0110, M=1 -> RESULT=8'hC5, AEQB=0.
//     Change A/B during RUN -> RESULT is unchanged.
//  6. Handshake: hold RES_READY=0 for 5 cycles -> RES_VALID and RESULT held.
//     START pulses in RUN/DONE are ignored.
//     RES_READY=1 with START=1 -> IDLE first, accept one cycle later.

Source files
------------

// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: FSM encoding and
// the 74x181 function-select codes used by the control unit.
package alu_nibble_sequencer_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // FN_SUB and FN_XOR share a code; M selects arithmetic vs. logic.
    localparam logic [NIBBLE_W-1:0] FN_ADD = 4'b1001;
    localparam logic [NIBBLE_W-1:0] FN_SUB = 4'b0110;
    localparam logic [NIBBLE_W-1:0] FN_XOR = 4'b0110;
    localparam logic [NIBBLE_W-1:0] FN_AND = 4'b1011;
    localparam logic [NIBBLE_W-1:0] FN_OR  = 4'b1110;

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Request/response bus between the control unit (master) and the
// nibble-serial ALU sequencer (slave).
interface alu_nibble_sequencer_if
    import alu_nibble_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic                start;
    logic                ready;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [NIBBLE_W-1:0] s;
    logic                m;
    logic                cin;
    logic                res_valid;
    logic                res_ready;
    logic [WIDTH-1:0]    result;
    logic                cout;
    logic                aeqb;
    logic                zero;

    modport master (
        output start, a, b, s, m, cin, res_ready,
        input  ready, res_valid, result, cout, aeqb, zero
    );

    modport slave (
        input  start, a, b, s, m, cin, res_ready,
        output ready, res_valid, result, cout, aeqb, zero
    );

endinterface

// File: rtl/alu_nibble_sequencer_ta181_bar.sv
// 4-bit 74x181-style ALU slice with active-low data pins (A_BAR, B_BAR, F_BAR)
// and active-low carries (CI=1 / CO=1 mean no carry).
module ta181_bar
    import alu_nibble_sequencer_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_bar,
    input  logic [NIBBLE_W-1:0] b_bar,
    input  logic [NIBBLE_W-1:0] s,
    input  logic                m,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] f_bar,
    output logic                co,
    output logic                aeqb,
    output logic                p_bar,
    output logic                g_bar
);
    logic [NIBBLE_W-1:0] a, b, d, e, f;
    logic [NIBBLE_W:0]   c;

    always_comb begin
        a = ~a_bar;
        b = ~b_bar;
        // d/e are the classic 181 first-level terms: ~d propagates, ~e generates.
        d = ~(a | (b & {NIBBLE_W{s[0]}}) | (~b & {NIBBLE_W{s[1]}}));
        e = ~((a & ~b & {NIBBLE_W{s[2]}}) | (a & b & {NIBBLE_W{s[3]}}));
        c = '0;
        c[0] = ~ci;
        for (int i = 0; i < NIBBLE_W; i++) begin
            c[i+1] = ~e[i] | (~d[i] & c[i]);
        end
        f = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            f[i] = (d[i] ^ e[i]) ^ (m | c[i]);
        end
        f_bar = ~f;
        co    = ~c[NIBBLE_W];
        aeqb  = &f_bar;
        p_bar = ~(&(~d));
        g_bar = ~(~e[3] | (~d[3] & ~e[2]) | (~d[3] & ~d[2] & ~e[1])
                  | (~d[3] & ~d[2] & ~d[1] & ~e[0]));
    end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Runs WIDTH-bit ALU operations through one 4-bit ta181_bar slice, one nibble
// per cycle LSB first, chaining the carry through a register.
module alu_nibble_sequencer
    import alu_nibble_sequencer_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_nibble_sequencer_if.slave bus
);
    localparam int WIDTH = NIBBLE_W * NIBBLES;
    localparam int CNT_W = $clog2(NIBBLES) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_t              state, state_nxt;
    logic [WIDTH-1:0]    a_q, b_q, result_q, result_nxt;
    logic [NIBBLE_W-1:0] s_q, a_nib, b_nib, f_bar;
    logic                m_q, carry_q, cout_q, aeqb_q, zero_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                co, slice_aeqb, p_bar_unused, g_bar_unused;

    always_comb begin
        a_nib      = '0;
        b_nib      = '0;
        result_nxt = result_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_nib = a_q[NIBBLE_W*i +: NIBBLE_W];
                b_nib = b_q[NIBBLE_W*i +: NIBBLE_W];
                result_nxt[NIBBLE_W*i +: NIBBLE_W] = ~f_bar;
            end
        end
    end

    ta181_bar u_slice (
        .a_bar (~a_nib),
        .b_bar (~b_nib),
        .s     (s_q),
        .m     (m_q),
        .ci    (carry_q),
        .f_bar (f_bar),
        .co    (co),
        .aeqb  (slice_aeqb),
        .p_bar (p_bar_unused),
        .g_bar (g_bar_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.ready     = 1'b0;
        bus.res_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                if (cnt_q == LAST) state_nxt = DONE;
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter holds at LAST on the final pass so the nibble mux never goes out of range.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b1;
            aeqb_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            s_q     <= bus.s;
            m_q     <= bus.m;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            aeqb_q  <= 1'b1;
        end else if (state == RUN) begin
            result_q <= result_nxt;
            carry_q  <= co;
            aeqb_q   <= aeqb_q & slice_aeqb;
            if (cnt_q == LAST) begin
                cout_q <= co;
                zero_q <= (result_nxt == '0);
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.aeqb   = aeqb_q;
    assign bus.zero   = zero_q;

endmodule
